axi_bram_log_reader: RTL and testbench
======================================

# axi_bram_log_reader

Drains the AXI transaction log out of the logging BRAM array after capture and streams it as 32-bit words over a valid/ready interface. It reads one 96-bit entry per BRAM read, serializes it low word first, and marks the final word of the run. It sits on the second BRAM port, opposite the logger's write port, and feeds a host-readable FIFO or DMA engine.

## Interface
- LOGGING_DATA_BITW, 96: entry width; fixed at 3 × 32.
- NUM_SER_BRAMS, 12: serial BRAM depth in 1024-entry units; MAX_ENTRIES = 1024*NUM_SER_BRAMS.
- LOGGING_ADDR_BITW, log2(1024*NUM_SER_BRAMS)+2: BRAM address width. Entry index is shifted left by 2.
- CNT_BITW, log2(1024*NUM_SER_BRAMS)+1: entry-count width; holds MAX_ENTRIES.
- Clk_CI  in  1  the only clock.
- Rst_RBI  in  1  reset, asynchronous, active-low.
- Start_SI  in  1  single-cycle start request; sampled only in IDLE.
- Abort_SI  in  1  terminates a drain.
- NumEntries_DI  in  CNT_BITW  number of valid entries; sampled on the accepted Start_SI.
- Busy_SO  out  1  high in every state except IDLE.
- Done_SO  out  1  one-cycle pulse when a drain completes normally.
- BramRdEn_SO  out  1  BRAM read enable.
- BramAddr_DO  out  LOGGING_ADDR_BITW  entry index << 2.
- BramRdData_DI  in  LOGGING_DATA_BITW  read data, valid the cycle after BramRdEn_SO.
- OutValid_SO  out  1  stream word valid.
- OutReady_SI  in  1  stream sink ready.
- OutData_DO  out  32  stream word.
- OutLast_SO  out  1  high on the final word of the final entry.

## Operation
- FSM states are IDLE, FETCH, CAPT, SEND and DONE.
- **IDLE, on Start_SI:**
  - Latch Count = min(NumEntries_DI, MAX_ENTRIES).
  - Clear the entry index Idx.
  - If Count == 0, go to DONE. Otherwise go to FETCH.
- **FETCH:** drive BramRdEn_SO=1 and BramAddr_DO=Idx<<2, then go to CAPT.
- **CAPT:** register BramRdData_DI into the 96-bit entry buffer, set word index W=0, then go to SEND.
- **SEND:**
  - OutValid_SO=1 and OutData_DO=buffer[32*W +: 32].
  - Word order: W=0 is {len,id} bits[31:0], W=1 is address bits[63:32], W=2 is timestamp bits[95:64].
  - On handshake with W<2: W increments.
  - On handshake with W==2 and Idx+1<Count: Idx increments and the FSM goes to FETCH.
  - On handshake with W==2 and Idx+1==Count: go to DONE.
- **DONE:** Done_SO=1 for one cycle, then go to IDLE.
- OutLast_SO = (state==SEND) && W==2 && Idx+1==Count.
- Start_SI outside IDLE is ignored.
- NumEntries_DI changes after start have no effect.
- **Abort_SI:**
  - Acts in any non-IDLE state and has priority over all other transitions.
  - Next state is IDLE. Done_SO is not pulsed.
  - OutValid_SO may drop without a handshake; this is the only permitted case.
- Stream rule: while OutValid_SO=1 and OutReady_SI=0, OutData_DO and OutLast_SO hold stable.
- The block never writes the BRAM. BRAM contents are untouched.

## Timing
- Reset value of every output is 0. Reset is asynchronous and takes effect immediately, including mid-drain. The state returns to IDLE and the buffer, Idx and W clear.
- Start_SI accepted at edge 0 gives FETCH in cycle 1, CAPT in cycle 2 and the first OutValid_SO in cycle 3.
- BRAM read latency is exactly 1 cycle. No other read is outstanding.
- With OutReady_SI held at 1, an entry takes 5 cycles: FETCH, CAPT and 3 SEND. N entries take 5N cycles.
- Done_SO is asserted in the cycle after the last handshake.
- Count == 0: Done_SO is asserted in cycle 1 with no BRAM read and no stream word.
- Count clamps to MAX_ENTRIES, so the last address is (MAX_ENTRIES-1)<<2. No wrap-around occurs.
- Abort_SI and a handshake in the same cycle: the word counts as transferred, and the FSM still goes to IDLE.

## Structure
- Package axi_bram_log_pkg holds:
  - the state enum;
  - field offsets shared with the logger: ID_LOW/HIGH, LEN_LOW/HIGH, ADDR 63:32, TS 95:64;
  - WORDS_PER_ENTRY = 3;
  - the log2 function.
- Sub-module axi_bram_log_serializer owns the 96→32 buffer, W, OutValid/OutData handshake and last-word flag. The top keeps the FSM, Idx/Count and the BRAM port.

## Test plan
- **Basic drain:** preload 2 entries ({ts=0x10,addr=0xA000_0000,len=3,id=5}, {ts=0x11,addr=0xA000_0040,len=0,id=6}), NumEntries=2, OutReady=1.
  - Stream: 0x0000_0305, 0xA000_0000, 0x0000_0010, 0x0000_0006, 0xA000_0040, 0x0000_0011.
  - Last word carries OutLast_SO. Done_SO pulses at cycle 11.
- **Backpressure:** OutReady toggles every cycle. Same 6 words with no loss. Data is stable while stalled.
- **Zero count:** NumEntries=0. No BramRdEn_SO, Done_SO at cycle 1, Busy_SO high for 1 cycle.
- **Clamp/full:** NumEntries=MAX_ENTRIES+5.
  - Exactly 3*MAX_ENTRIES words; last read address is (MAX_ENTRIES-1)<<2.
  - OutLast_SO occurs only on the final word.
- **Abort:** Abort_SI while sending W=1 of entry 3. Next cycle IDLE, OutValid_SO=0, no Done_SO. A new Start_SI restarts from address 0.
- **Async reset:** Rst_RBI asserted mid-SEND between edges. All outputs go to 0 immediately, and there is no activity until the next Start_SI.

Source files
------------

// File: rtl/axi_bram_log_pkg.sv
// Shared definitions for the AXI transaction-log BRAM drain path.
// Field offsets match the logger's 96-bit entry layout.
package axi_bram_log_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPT,
        ST_SEND,
        ST_DONE
    } state_e;

    localparam int ID_LOW    = 0;
    localparam int ID_HIGH   = 7;
    localparam int LEN_LOW   = 8;
    localparam int LEN_HIGH  = 15;
    localparam int ADDR_LOW  = 32;
    localparam int ADDR_HIGH = 63;
    localparam int TS_LOW    = 64;
    localparam int TS_HIGH   = 95;

    localparam int WORD_BITW       = 32;
    localparam int WORDS_PER_ENTRY = 3;

    function automatic int log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_bram_log_serializer.sv
// Holds one 96-bit log entry and emits it as three 32-bit stream words,
// low word first, with a last flag on the final word of the final entry.
module axi_bram_log_serializer
    import axi_bram_log_pkg::*;
#(
    parameter int LOGGING_DATA_BITW = 96
) (
    input  logic                         Clk_CI,
    input  logic                         Rst_RBI,
    input  logic                         Load_SI,
    input  logic                         Clear_SI,
    input  logic                         LastEntry_SI,
    input  logic [LOGGING_DATA_BITW-1:0] Data_DI,
    output logic                         OutValid_SO,
    input  logic                         OutReady_SI,
    output logic [WORD_BITW-1:0]         OutData_DO,
    output logic                         OutLast_SO,
    output logic                         WordDone_SO
);

    logic [LOGGING_DATA_BITW-1:0] buf_q, buf_d;
    logic [1:0]                   w_q, w_d;
    logic                         valid_q, valid_d;
    logic                         last_q, last_d;
    logic                         hs;
    logic                         last_word;

    assign hs        = valid_q && OutReady_SI;
    assign last_word = (w_q == 2'(WORDS_PER_ENTRY - 1));

    always_comb begin
        buf_d   = buf_q;
        w_d     = w_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (Clear_SI) begin
            valid_d = 1'b0;
        end else if (Load_SI) begin
            buf_d   = Data_DI;
            w_d     = 2'd0;
            valid_d = 1'b1;
            last_d  = LastEntry_SI;
        end else if (hs) begin
            if (last_word) valid_d = 1'b0;
            else           w_d     = w_q + 2'd1;
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            buf_q   <= '0;
            w_q     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            w_q     <= w_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        OutData_DO = '0;
        if (valid_q) begin
            unique case (w_q)
                2'd0:    OutData_DO = buf_q[LEN_HIGH+16:ID_LOW];
                2'd1:    OutData_DO = buf_q[ADDR_HIGH:ADDR_LOW];
                default: OutData_DO = buf_q[TS_HIGH:TS_LOW];
            endcase
        end
    end

    assign OutValid_SO = valid_q;
    assign OutLast_SO  = valid_q && last_word && last_q;
    assign WordDone_SO = hs && last_word;

endmodule

// File: rtl/axi_bram_log_reader.sv
// Drains the transaction log from the logging BRAM read port and streams
// each 96-bit entry as three 32-bit words over valid/ready.
module axi_bram_log_reader
    import axi_bram_log_pkg::*;
#(
    parameter int LOGGING_DATA_BITW = 96,
    parameter int NUM_SER_BRAMS     = 12,
    parameter int LOGGING_ADDR_BITW = log2(1024 * NUM_SER_BRAMS) + 2,
    parameter int CNT_BITW          = log2(1024 * NUM_SER_BRAMS) + 1
) (
    input  logic                         Clk_CI,
    input  logic                         Rst_RBI,
    input  logic                         Start_SI,
    input  logic                         Abort_SI,
    input  logic [CNT_BITW-1:0]          NumEntries_DI,
    output logic                         Busy_SO,
    output logic                         Done_SO,
    output logic                         BramRdEn_SO,
    output logic [LOGGING_ADDR_BITW-1:0] BramAddr_DO,
    input  logic [LOGGING_DATA_BITW-1:0] BramRdData_DI,
    output logic                         OutValid_SO,
    input  logic                         OutReady_SI,
    output logic [WORD_BITW-1:0]         OutData_DO,
    output logic                         OutLast_SO
);

    localparam int MAX_ENTRIES = 1024 * NUM_SER_BRAMS;

    state_e                       state_q, state_d;
    logic [CNT_BITW-1:0]          idx_q, idx_d;
    logic [CNT_BITW-1:0]          count_q, count_d;
    logic                         rd_en_q, rd_en_d;
    logic [LOGGING_ADDR_BITW-1:0] addr_q, addr_d;
    logic                         done_q, done_d;
    logic                         busy_q, busy_d;
    logic [CNT_BITW-1:0]          num_clamped;
    logic                         is_last;
    logic                         abort_act;
    logic                         word_done;

    assign num_clamped = (NumEntries_DI > CNT_BITW'(MAX_ENTRIES)) ?
                         CNT_BITW'(MAX_ENTRIES) : NumEntries_DI;
    assign is_last     = ((idx_q + CNT_BITW'(1)) == count_q);
    assign abort_act   = Abort_SI && (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (Start_SI) begin
                    count_d = num_clamped;
                    idx_d   = '0;
                    state_d = (num_clamped == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_CAPT;
            ST_CAPT:  state_d = ST_SEND;
            ST_SEND: begin
                if (word_done) begin
                    if (is_last) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + CNT_BITW'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        // abort wins over every other transition
        if (abort_act) state_d = ST_IDLE;
        rd_en_d = (state_d == ST_FETCH);
        addr_d  = rd_en_d ? LOGGING_ADDR_BITW'({idx_d, 2'b00}) : '0;
        done_d  = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            count_q <= '0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign Busy_SO     = busy_q;
    assign Done_SO     = done_q;
    assign BramRdEn_SO = rd_en_q;
    assign BramAddr_DO = addr_q;

    axi_bram_log_serializer #(
        .LOGGING_DATA_BITW(LOGGING_DATA_BITW)
    ) u_ser (
        .Clk_CI       (Clk_CI),
        .Rst_RBI      (Rst_RBI),
        .Load_SI      ((state_q == ST_CAPT) && !Abort_SI),
        .Clear_SI     (abort_act),
        .LastEntry_SI (is_last),
        .Data_DI      (BramRdData_DI),
        .OutValid_SO  (OutValid_SO),
        .OutReady_SI  (OutReady_SI),
        .OutData_DO   (OutData_DO),
        .OutLast_SO   (OutLast_SO),
        .WordDone_SO  (word_done)
    );

endmodule

// File: tb/tb_axi_bram_log_reader.sv
// Directed bench for axi_bram_log_reader with a 1-cycle BRAM read model.
module tb_axi_bram_log_reader;
    import axi_bram_log_pkg::*;

    localparam int MAXE = 1024 * 12;
    localparam int CW   = log2(MAXE) + 1;
    localparam int AW   = log2(MAXE) + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] num = '0;
    logic          busy, done, rd_en;
    logic [AW-1:0] addr;
    logic [95:0]   rd_data = '0;
    logic          valid;
    logic          ready = 1'b0;
    logic [31:0]   data;
    logic          last;

    logic [95:0]   mem [MAXE];
    logic [31:0]   got [8];
    int            ngot;
    int            total = 0;
    int            bad = 0;

    axi_bram_log_reader dut (
        .Clk_CI        (clk),
        .Rst_RBI       (rst_n),
        .Start_SI      (start),
        .Abort_SI      (abort),
        .NumEntries_DI (num),
        .Busy_SO       (busy),
        .Done_SO       (done),
        .BramRdEn_SO   (rd_en),
        .BramAddr_DO   (addr),
        .BramRdData_DI (rd_data),
        .OutValid_SO   (valid),
        .OutReady_SI   (ready),
        .OutData_DO    (data),
        .OutLast_SO    (last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[addr[AW-1:2]];
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " done"}, 64'(done), 64'd0);
        chk({tag, " rd_en"}, 64'(rd_en), 64'd0);
        chk({tag, " addr"}, 64'(addr), 64'd0);
        chk({tag, " valid"}, 64'(valid), 64'd0);
        chk({tag, " data"}, 64'(data), 64'd0);
        chk({tag, " last"}, 64'(last), 64'd0);
    endtask

    function automatic logic [95:0] mk(input logic [31:0] ts,
                                       input logic [31:0] a,
                                       input logic [7:0] len,
                                       input logic [7:0] id);
        logic [95:0] e;
        e = '0;
        e[TS_HIGH:TS_LOW]     = ts;
        e[ADDR_HIGH:ADDR_LOW] = a;
        e[LEN_HIGH:LEN_LOW]   = len;
        e[ID_HIGH:ID_LOW]     = id;
        return e;
    endfunction

    task automatic drain(input int n_cnt, input int n_eff, input bit bp,
                         input int exp_done, input string tag);
        int          words, werr, lerr, lastn, rdn, serr, busyn, done_cyc;
        logic [AW-1:0] a_first, a_last;
        bit          prev_stall;
        logic [31:0] pd, ew;
        logic        pl;
        logic [95:0] ent;
        words = 0; werr = 0; lerr = 0; lastn = 0; rdn = 0;
        serr = 0; busyn = 0; done_cyc = -1;
        a_first = '1; a_last = '1;
        prev_stall = 1'b0; pd = '0; pl = 1'b0;
        ngot = 0;
        num = CW'(n_cnt);
        start = 1'b1;
        tick;
        start = 1'b0;
        num = '1;
        for (int cyc = 1; cyc <= 8 * n_eff + 20; cyc++) begin
            if (rd_en) begin
                if (rdn == 0) a_first = addr;
                a_last = addr;
                rdn++;
            end
            if (busy) busyn++;
            if (prev_stall && (!valid || data !== pd || last !== pl)) serr++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            ready = bp ? cyc[0] : 1'b1;
            if (valid && ready) begin
                ent = mem[words / 3];
                ew  = 32'(ent >> (32 * (words % 3)));
                if (data !== ew) werr++;
                if (last !== (words == 3 * n_eff - 1)) lerr++;
                if (last) lastn++;
                if (ngot < 8) begin
                    got[ngot] = data;
                    ngot++;
                end
                words++;
            end
            prev_stall = valid && !ready;
            pd = data;
            pl = last;
            tick;
        end
        chk({tag, " done_cycle"}, 64'(done_cyc), 64'(exp_done));
        chk({tag, " words"}, 64'(words), 64'(3 * n_eff));
        chk({tag, " word_errs"}, 64'(werr), 64'd0);
        chk({tag, " last_errs"}, 64'(lerr), 64'd0);
        chk({tag, " last_count"}, 64'(lastn), 64'(n_eff > 0));
        chk({tag, " reads"}, 64'(rdn), 64'(n_eff));
        chk({tag, " busy_cycles"}, 64'(busyn), 64'(exp_done));
        chk({tag, " stall_errs"}, 64'(serr), 64'd0);
        if (n_eff > 0) begin
            chk({tag, " first_addr"}, 64'(a_first), 64'd0);
            chk({tag, " last_addr"}, 64'(a_last), 64'((n_eff - 1) << 2));
        end
        tick;
        chk({tag, " busy_after"}, 64'(busy), 64'd0);
        chk({tag, " done_after"}, 64'(done), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < MAXE; i++) begin
            mem[i] = {32'(i) ^ 32'h5A5A_0000, 32'hB000_0000 + 32'(i << 6),
                      32'(i) * 32'h0001_0003};
        end
        mem[0] = mk(32'h10, 32'hA000_0000, 8'd3, 8'd5);
        mem[1] = mk(32'h11, 32'hA000_0040, 8'd0, 8'd6);

        #7;
        chk_idle("reset");
        #5;
        rst_n = 1'b1;
        tick;

        drain(2, 2, 1'b0, 11, "basic");
        chk("basic w0", 64'(got[0]), 64'h0000_0305);
        chk("basic w1", 64'(got[1]), 64'hA000_0000);
        chk("basic w2", 64'(got[2]), 64'h0000_0010);
        chk("basic w3", 64'(got[3]), 64'h0000_0006);
        chk("basic w4", 64'(got[4]), 64'hA000_0040);
        chk("basic w5", 64'(got[5]), 64'h0000_0011);

        drain(2, 2, 1'b1, 16, "bp");
        chk("bp w0", 64'(got[0]), 64'h0000_0305);
        chk("bp w5", 64'(got[5]), 64'h0000_0011);

        drain(0, 0, 1'b0, 1, "zero");

        drain(MAXE + 5, MAXE, 1'b0, 5 * MAXE + 1, "clamp");

        ready = 1'b1;
        num = CW'(5);
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (13) tick;
        chk("abort pre valid", 64'(valid), 64'd1);
        chk("abort pre data", 64'(data), 64'(mem[2][63:32]));
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort valid", 64'(valid), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort rd_en", 64'(rd_en), 64'd0);
        tick;
        chk("abort done2", 64'(done), 64'd0);
        drain(2, 2, 1'b0, 11, "restart");

        ready = 1'b1;
        num = CW'(2);
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (3) tick;
        chk("rst pre valid", 64'(valid), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        #7;
        rst_n = 1'b1;
        repeat (3) tick;
        chk_idle("post_rst_idle");
        drain(1, 1, 1'b0, 6, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
